// File: rtl/step_counter_seq_if.sv
// Control/status bundle for step_counter_seq: run request, config, and counter status.
// Carries the optional wraps counter when STEP_COUNTER_SEQ_WRAPCNT_EN is defined.
interface step_counter_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enable;
    logic             start;
    logic             last_sel;
    logic [WIDTH-1:0] last_in;
    logic             mode;
    logic             pause;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;
`ifdef STEP_COUNTER_SEQ_WRAPCNT_EN
    logic [WIDTH-1:0] wraps;
`endif

    modport master (
        output enable,
        output start,
        output last_sel,
        output last_in,
        output mode,
        output pause,
        input  count,
        input  busy,
        input  tc,
`ifdef STEP_COUNTER_SEQ_WRAPCNT_EN
        input  wraps,
`endif
        input  done
    );

    modport slave (
        input  enable,
        input  start,
        input  last_sel,
        input  last_in,
        input  mode,
        input  pause,
        output count,
        output busy,
        output tc,
`ifdef STEP_COUNTER_SEQ_WRAPCNT_EN
        output wraps,
`endif
        output done
    );
endinterface

// File: rtl/step_counter_seq.sv
// Programmable 0..last sequencer with start/busy/done handshake, one-shot or wrap mode, pause.
// Optional saturating wrap counter enabled by defining STEP_COUNTER_SEQ_WRAPCNT_EN.
module step_counter_seq #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEFAULT_LAST = 7
) (
    input logic               clk,
    input logic               rstn,
    step_counter_seq_if.slave bus
);
    localparam logic [WIDTH-1:0] LastDefault = WIDTH'(DEFAULT_LAST);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_last;
    logic             r_mode;
`ifdef STEP_COUNTER_SEQ_WRAPCNT_EN
    logic [WIDTH-1:0] r_wraps;
`endif

    logic             w_at_last;
    logic [WIDTH-1:0] w_start_last;

    assign w_at_last    = (r_count == r_last);
    assign w_start_last = bus.last_sel ? bus.last_in : LastDefault;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_last  <= LastDefault;
            r_mode  <= 1'b0;
`ifdef STEP_COUNTER_SEQ_WRAPCNT_EN
            r_wraps <= '0;
`endif
        end else if (!bus.enable) begin
            // Forced idle; the latched configuration is kept.
            r_state <= StIdle;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef STEP_COUNTER_SEQ_WRAPCNT_EN
            r_wraps <= '0;
`endif
        end else begin
            unique case (r_state)
                // DONE accepts start too, so back-to-back runs have no idle gap.
                StIdle, StDone: begin
                    r_count <= '0;
                    r_done  <= 1'b0;
                    if (bus.start) begin
                        r_state <= StRun;
                        r_busy  <= 1'b1;
                        r_last  <= w_start_last;
                        r_mode  <= bus.mode;
`ifdef STEP_COUNTER_SEQ_WRAPCNT_EN
                        r_wraps <= '0;
`endif
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                StRun: begin
                    if (!bus.pause) begin
                        if (!w_at_last) begin
                            r_count <= r_count + WIDTH'(1);
                        end else if (r_mode) begin
                            r_count <= '0;
`ifdef STEP_COUNTER_SEQ_WRAPCNT_EN
                            if (r_wraps != '1) begin
                                r_wraps <= r_wraps + WIDTH'(1);
                            end
`endif
                        end else begin
                            r_state <= StDone;
                            r_count <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count = r_count;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    // r_busy is only set in RUN, so tc needs no decode of r_state.
    assign bus.tc    = r_busy & w_at_last;
`ifdef STEP_COUNTER_SEQ_WRAPCNT_EN
    assign bus.wraps = r_wraps;
`endif

endmodule

// File: tb/tb_step_counter_seq.sv
// Directed self-checking bench for step_counter_seq.
// Checks the wraps output as well when STEP_COUNTER_SEQ_WRAPCNT_EN is defined.
module tb_step_counter_seq;
    localparam int unsigned W = 8;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;

    step_counter_seq_if #(.WIDTH(W)) dut_if ();

    step_counter_seq #(
        .WIDTH        (W),
        .DEFAULT_LAST (7)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach summary, time=%0t limit=2000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic sel, input logic [W-1:0] last, input logic md);
        dut_if.last_sel = sel;
        dut_if.last_in  = last;
        dut_if.mode     = md;
        dut_if.start    = 1'b1;
        step();
        dut_if.start    = 1'b0;
    endtask

    task automatic test_reset();
        rstn            = 1'b0;
        dut_if.enable   = 1'b0;
        dut_if.start    = 1'b0;
        dut_if.last_sel = 1'b0;
        dut_if.last_in  = '0;
        dut_if.mode     = 1'b0;
        dut_if.pause    = 1'b0;
        #1;
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b000, 8'd0}) begin
            n_errors++;
            $display("FAIL reset: got busy/tc/done=%b%b%b count=%0d, expected 000 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
        step();
        step();
        rstn          = 1'b1;
        dut_if.enable = 1'b1;
        step();
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b000, 8'd0}) begin
            n_errors++;
            $display("FAIL reset_idle: got busy/tc/done=%b%b%b count=%0d, expected 000 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
    endtask

    task automatic test_oneshot_default();
        logic [W-1:0] ec;
        start_run(1'b0, 8'd200, 1'b0);
        for (int i = 0; i < 8; i++) begin
            ec = W'(i);
            n_checks++;
            if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {1'b1, i == 7, 1'b0, ec})
            begin
                n_errors++;
                $display("FAIL oneshot_default[%0d]: got busy/tc/done=%b%b%b count=%0d, expected 1%b0 count=%0d",
                         i, dut_if.busy, dut_if.tc, dut_if.done, dut_if.count, i == 7, ec);
            end
            step();
        end
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b001, 8'd0}) begin
            n_errors++;
            $display("FAIL oneshot_done: got busy/tc/done=%b%b%b count=%0d, expected 001 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
        step();
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b000, 8'd0}) begin
            n_errors++;
            $display("FAIL oneshot_idle: got busy/tc/done=%b%b%b count=%0d, expected 000 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
    endtask

    task automatic test_continuous();
        logic [W-1:0] ec;
        start_run(1'b1, 8'd3, 1'b1);
        for (int i = 0; i < 12; i++) begin
            ec = W'(i % 4);
            n_checks++;
            if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {1'b1, ec == 3, 1'b0, ec})
            begin
                n_errors++;
                $display("FAIL continuous[%0d]: got busy/tc/done=%b%b%b count=%0d, expected 1%b0 count=%0d",
                         i, dut_if.busy, dut_if.tc, dut_if.done, dut_if.count, ec == 3, ec);
            end
`ifdef STEP_COUNTER_SEQ_WRAPCNT_EN
            n_checks++;
            if (dut_if.wraps !== W'(i / 4)) begin
                n_errors++;
                $display("FAIL continuous_wraps[%0d]: got %0d expected %0d", i, dut_if.wraps, i / 4);
            end
`endif
            step();
        end
        n_checks++;
        if ({dut_if.busy, dut_if.done, dut_if.count} !== {2'b10, 8'd0}) begin
            n_errors++;
            $display("FAIL continuous_after: got busy/done=%b%b count=%0d, expected 10 count=0",
                     dut_if.busy, dut_if.done, dut_if.count);
        end
`ifdef STEP_COUNTER_SEQ_WRAPCNT_EN
        n_checks++;
        if (dut_if.wraps !== 8'd3) begin
            n_errors++;
            $display("FAIL continuous_wraps_final: got %0d expected 3", dut_if.wraps);
        end
`endif
        dut_if.enable = 1'b0;
        step();
        dut_if.enable = 1'b1;
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b000, 8'd0}) begin
            n_errors++;
            $display("FAIL continuous_stop: got busy/tc/done=%b%b%b count=%0d, expected 000 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
`ifdef STEP_COUNTER_SEQ_WRAPCNT_EN
        n_checks++;
        if (dut_if.wraps !== 8'd0) begin
            n_errors++;
            $display("FAIL continuous_wraps_clear: got %0d expected 0", dut_if.wraps);
        end
`endif
    endtask

    task automatic test_pause();
        int           exp_cnt [9] = '{0, 1, 2, 2, 2, 2, 3, 4, 5};
        logic [W-1:0] ec;
        start_run(1'b1, 8'd5, 1'b0);
        for (int i = 0; i < 9; i++) begin
            ec = W'(exp_cnt[i]);
            n_checks++;
            if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {1'b1, ec == 5, 1'b0, ec})
            begin
                n_errors++;
                $display("FAIL pause[%0d]: got busy/tc/done=%b%b%b count=%0d, expected 1%b0 count=%0d",
                         i, dut_if.busy, dut_if.tc, dut_if.done, dut_if.count, ec == 5, ec);
            end
            dut_if.pause = (i >= 2 && i <= 4);
            step();
        end
        dut_if.pause = 1'b0;
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b001, 8'd0}) begin
            n_errors++;
            $display("FAIL pause_done: got busy/tc/done=%b%b%b count=%0d, expected 001 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
        step();
    endtask

    task automatic test_enable_drop();
        start_run(1'b1, 8'd9, 1'b1);
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if ({dut_if.busy, dut_if.count} !== {1'b1, 8'd4}) begin
            n_errors++;
            $display("FAIL enable_pre: got busy=%b count=%0d, expected busy=1 count=4",
                     dut_if.busy, dut_if.count);
        end
        dut_if.enable = 1'b0;
        step();
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b000, 8'd0}) begin
            n_errors++;
            $display("FAIL enable_drop: got busy/tc/done=%b%b%b count=%0d, expected 000 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
        dut_if.enable = 1'b1;
        step();
        step();
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b000, 8'd0}) begin
            n_errors++;
            $display("FAIL enable_stays_idle: got busy/tc/done=%b%b%b count=%0d, expected 000 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
    endtask

    task automatic test_back_to_back();
        start_run(1'b1, 8'd2, 1'b0);
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b001, 8'd0}) begin
            n_errors++;
            $display("FAIL b2b_first_done: got busy/tc/done=%b%b%b count=%0d, expected 001 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
        start_run(1'b1, 8'd0, 1'b0);
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b110, 8'd0}) begin
            n_errors++;
            $display("FAIL b2b_run: got busy/tc/done=%b%b%b count=%0d, expected 110 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
        step();
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b001, 8'd0}) begin
            n_errors++;
            $display("FAIL b2b_second_done: got busy/tc/done=%b%b%b count=%0d, expected 001 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
        step();
        n_checks++;
        if ({dut_if.busy, dut_if.done} !== 2'b00) begin
            n_errors++;
            $display("FAIL b2b_idle: got busy/done=%b%b, expected 00", dut_if.busy, dut_if.done);
        end
    endtask

    task automatic test_last_zero_continuous();
        start_run(1'b1, 8'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b110, 8'd0}) begin
                n_errors++;
                $display("FAIL zero_cont[%0d]: got busy/tc/done=%b%b%b count=%0d, expected 110 count=0",
                         i, dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
            end
`ifdef STEP_COUNTER_SEQ_WRAPCNT_EN
            n_checks++;
            if (dut_if.wraps !== W'(i)) begin
                n_errors++;
                $display("FAIL zero_cont_wraps[%0d]: got %0d expected %0d", i, dut_if.wraps, i);
            end
`endif
            step();
        end
        dut_if.enable = 1'b0;
        step();
        dut_if.enable = 1'b1;
    endtask

    task automatic test_full_range();
        logic [W-1:0] ec;
        start_run(1'b1, 8'd255, 1'b0);
        for (int i = 0; i < 256; i++) begin
            ec = W'(i);
            n_checks++;
            if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {1'b1, i == 255, 1'b0, ec})
            begin
                n_errors++;
                $display("FAIL full_range[%0d]: got busy/tc/done=%b%b%b count=%0d, expected 1%b0 count=%0d",
                         i, dut_if.busy, dut_if.tc, dut_if.done, dut_if.count, i == 255, ec);
            end
            step();
        end
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b001, 8'd0}) begin
            n_errors++;
            $display("FAIL full_range_done: got busy/tc/done=%b%b%b count=%0d, expected 001 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
        step();
    endtask

    task automatic test_async_reset();
        logic [W-1:0] ec;
        start_run(1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ec = W'(i);
            n_checks++;
            if ({dut_if.busy, dut_if.count} !== {1'b1, ec}) begin
                n_errors++;
                $display("FAIL start_ignored[%0d]: got busy=%b count=%0d, expected busy=1 count=%0d",
                         i, dut_if.busy, dut_if.count, ec);
            end
            // Re-request with a different config mid-run; it must have no effect.
            if (i == 2) begin
                dut_if.start    = 1'b1;
                dut_if.last_sel = 1'b1;
                dut_if.last_in  = 8'd1;
                dut_if.mode     = 1'b1;
            end
            if (i == 4) dut_if.start = 1'b0;
            step();
        end
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.count} !== {2'b10, 8'd6}) begin
            n_errors++;
            $display("FAIL async_pre: got busy/tc=%b%b count=%0d, expected 10 count=6",
                     dut_if.busy, dut_if.tc, dut_if.count);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b000, 8'd0}) begin
            n_errors++;
            $display("FAIL async_reset: got busy/tc/done=%b%b%b count=%0d, expected 000 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
        step();
        rstn = 1'b1;
        step();
        step();
        n_checks++;
        if ({dut_if.busy, dut_if.tc, dut_if.done, dut_if.count} !== {3'b000, 8'd0}) begin
            n_errors++;
            $display("FAIL async_no_resume: got busy/tc/done=%b%b%b count=%0d, expected 000 count=0",
                     dut_if.busy, dut_if.tc, dut_if.done, dut_if.count);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_oneshot_default();
        test_continuous();
        test_pause();
        test_enable_drop();
        test_back_to_back();
        test_last_zero_continuous();
        test_full_range();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
